// File: rtl/tlb_jtlb_mp_if.sv
// Entry type and CP0/MMU-side interface of the joint TLB.
// Optional mhit output present when TLB_MULTIHIT_EN is defined.
package tlb_jtlb_mp_pkg;
  typedef struct packed {
    logic [18:0] vpn2;
    logic [7:0]  asid;
    logic        g;
    logic [19:0] pfn0;
    logic [2:0]  c0;
    logic        d0;
    logic        v0;
    logic [19:0] pfn1;
    logic [2:0]  c1;
    logic        d1;
    logic        v1;
  } tlb_entry_t;
endpackage

interface tlb_jtlb_mp_if #(
  parameter int NUM_ENTRIES = 16,
  parameter int NUM_PORTS   = 2
);
  import tlb_jtlb_mp_pkg::*;
  localparam int IW = $clog2(NUM_ENTRIES);

  logic [NUM_PORTS-1:0]    lk_valid;
  logic [NUM_PORTS*32-1:0] lk_vaddr;
  logic [7:0]              asid;
  logic [NUM_PORTS-1:0]    rsp_valid;
  logic [NUM_PORTS*32-1:0] rsp_paddr;
  logic [NUM_PORTS-1:0]    rsp_hit;
  logic [NUM_PORTS-1:0]    rsp_v;
  logic [NUM_PORTS-1:0]    rsp_d;
  logic [NUM_PORTS*3-1:0]  rsp_c;
  logic                    op_valid;
  logic [2:0]              op_code;
  logic                    op_ready;
  logic [IW-1:0]           op_index;
  logic [31:0]             op_entryhi;
  tlb_entry_t              op_wdata;
  logic                    op_done;
  logic [31:0]             op_index_out;
  tlb_entry_t              op_rdata;
  logic                    wired_we;
  logic [IW-1:0]           wired_in;
  logic [IW-1:0]           random_out;
`ifdef TLB_MULTIHIT_EN
  logic [NUM_PORTS:0]      mhit;
`endif

  modport master (
    output lk_valid, lk_vaddr, asid, op_valid, op_code, op_index, op_entryhi, op_wdata,
    output wired_we, wired_in,
`ifdef TLB_MULTIHIT_EN
    input  mhit,
`endif
    input  rsp_valid, rsp_paddr, rsp_hit, rsp_v, rsp_d, rsp_c,
    input  op_ready, op_done, op_index_out, op_rdata, random_out
  );

  modport slave (
    input  lk_valid, lk_vaddr, asid, op_valid, op_code, op_index, op_entryhi, op_wdata,
    input  wired_we, wired_in,
`ifdef TLB_MULTIHIT_EN
    output mhit,
`endif
    output rsp_valid, rsp_paddr, rsp_hit, rsp_v, rsp_d, rsp_c,
    output op_ready, op_done, op_index_out, op_rdata, random_out
  );
endinterface

// File: rtl/tlb_jtlb_mp.sv
// Joint TLB: NUM_PORTS registered lookup ports, CP0 TLBP/TLBR/TLBWI/TLBWR/FLUSH, Random/Wired.
// Define TLB_MULTIHIT_EN to add the mhit multiple-match output.
module tlb_jtlb_mp
  import tlb_jtlb_mp_pkg::*;
#(
  parameter int NUM_ENTRIES = 16,
  parameter int NUM_PORTS   = 2
) (
  input logic           clk,
  input logic           reset,
  tlb_jtlb_mp_if.slave  bus
);
  localparam int IW = $clog2(NUM_ENTRIES);
  localparam logic [IW-1:0] MAX_IDX = IW'(NUM_ENTRIES - 1);

  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

  state_t                  state_reg;
  tlb_entry_t              tbl [NUM_ENTRIES];
  logic [IW-1:0]           random_reg, wired_reg, cnt_reg;
  logic                    op_ready_reg, op_done_reg;
  logic [31:0]             op_index_out_reg;
  tlb_entry_t              op_rdata_reg;
  logic [NUM_PORTS-1:0]    rsp_valid_reg, rsp_hit_reg, rsp_v_reg, rsp_d_reg;
  logic [NUM_PORTS*32-1:0] rsp_paddr_reg;
  logic [NUM_PORTS*3-1:0]  rsp_c_reg;

  logic                    lk_hit [NUM_PORTS];
  logic [IW-1:0]           lk_idx [NUM_PORTS];
  logic [31:0]             lk_pa  [NUM_PORTS];
  logic                    lk_v   [NUM_PORTS];
  logic                    lk_d   [NUM_PORTS];
  logic [2:0]              lk_c   [NUM_PORTS];
  logic [NUM_ENTRIES-1:0]  probe_match;
  logic [IW-1:0]           probe_idx;
  logic                    unused_entryhi;

  function automatic logic entry_match(input tlb_entry_t t, input logic [18:0] vpn2,
                                       input logic [7:0] key_asid);
    return (t.vpn2 == vpn2) && (t.g || (t.asid == key_asid));
  endfunction

  // Lowest set index wins among equal matches.
  function automatic logic [IW-1:0] first_set(input logic [NUM_ENTRIES-1:0] m);
    logic [IW-1:0] r;
    r = '0;
    for (int e = NUM_ENTRIES - 1; e >= 0; e--)
      if (m[e]) r = IW'(e);
    return r;
  endfunction

`ifdef TLB_MULTIHIT_EN
  logic                    lk_multi [NUM_PORTS];
  logic [NUM_PORTS-1:0]    mhit_lk_reg;
  logic                    mhit_op_reg;

  function automatic logic multi(input logic [NUM_ENTRIES-1:0] m);
    return (m & (m - 1'b1)) != '0;
  endfunction

  assign bus.mhit = {mhit_op_reg, mhit_lk_reg};
`endif

  assign unused_entryhi = ^bus.op_entryhi[12:8];

  // A lookup only hits a page whose V bit is set, so a flushed table misses everywhere;
  // TLBP matches on VPN2/ASID alone.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
      logic [31:0]            va;
      logic [NUM_ENTRIES-1:0] m;
      tlb_entry_t             sel;

      assign va = bus.lk_vaddr[32*gi +: 32];
      always_comb begin
        m = '0;
        for (int e = 0; e < NUM_ENTRIES; e++)
          m[e] = entry_match(tbl[e], va[31:13], bus.asid) && (va[12] ? tbl[e].v1 : tbl[e].v0);
      end
      assign lk_idx[gi] = first_set(m);
      assign sel        = tbl[lk_idx[gi]];
      assign lk_hit[gi] = (|m) && (state_reg != SWEEP);
      assign lk_pa[gi]  = {(va[12] ? sel.pfn1 : sel.pfn0), va[11:0]};
      assign lk_v[gi]   = va[12] ? sel.v1 : sel.v0;
      assign lk_d[gi]   = va[12] ? sel.d1 : sel.d0;
      assign lk_c[gi]   = va[12] ? sel.c1 : sel.c0;
`ifdef TLB_MULTIHIT_EN
      assign lk_multi[gi] = multi(m) && (state_reg != SWEEP);
`endif
    end
  endgenerate

  always_comb begin
    probe_match = '0;
    for (int e = 0; e < NUM_ENTRIES; e++)
      probe_match[e] = entry_match(tbl[e], bus.op_entryhi[31:13], bus.op_entryhi[7:0]);
  end
  assign probe_idx = first_set(probe_match);

  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid_reg <= '0;
      rsp_hit_reg   <= '0;
      rsp_v_reg     <= '0;
      rsp_d_reg     <= '0;
      rsp_paddr_reg <= '0;
      rsp_c_reg     <= '0;
`ifdef TLB_MULTIHIT_EN
      mhit_lk_reg   <= '0;
`endif
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        rsp_valid_reg[p] <= bus.lk_valid[p];
        if (bus.lk_valid[p] && lk_hit[p]) begin
          rsp_hit_reg[p]          <= 1'b1;
          rsp_paddr_reg[32*p +: 32] <= lk_pa[p];
          rsp_v_reg[p]            <= lk_v[p];
          rsp_d_reg[p]            <= lk_d[p];
          rsp_c_reg[3*p +: 3]     <= lk_c[p];
        end else begin
          rsp_hit_reg[p]          <= 1'b0;
          rsp_paddr_reg[32*p +: 32] <= '0;
          rsp_v_reg[p]            <= 1'b0;
          rsp_d_reg[p]            <= 1'b0;
          rsp_c_reg[3*p +: 3]     <= '0;
        end
`ifdef TLB_MULTIHIT_EN
        mhit_lk_reg[p] <= bus.lk_valid[p] && lk_multi[p];
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg        <= IDLE;
      random_reg       <= MAX_IDX;
      wired_reg        <= '0;
      cnt_reg          <= '0;
      op_ready_reg     <= 1'b1;
      op_done_reg      <= 1'b0;
      op_index_out_reg <= '0;
      op_rdata_reg     <= '0;
`ifdef TLB_MULTIHIT_EN
      mhit_op_reg      <= 1'b0;
`endif
      for (int e = 0; e < NUM_ENTRIES; e++)
        tbl[e] <= '0;
    end else begin
      op_done_reg <= 1'b0;
      if (bus.wired_we) begin
        wired_reg  <= bus.wired_in;
        random_reg <= MAX_IDX;
      end else if ((random_reg == wired_reg) || (wired_reg == MAX_IDX)) begin
        random_reg <= MAX_IDX;
      end else begin
        random_reg <= random_reg - 1'b1;
      end

      case (state_reg)
        SWEEP: begin
          tbl[cnt_reg].v0 <= 1'b0;
          tbl[cnt_reg].v1 <= 1'b0;
          cnt_reg         <= cnt_reg + 1'b1;
          if (cnt_reg == MAX_IDX) begin
            state_reg    <= DONE;
            op_ready_reg <= 1'b1;
            op_done_reg  <= 1'b1;
          end
        end
        default: begin
          // DONE only carries the flush completion pulse; it accepts ops like IDLE.
          state_reg <= IDLE;
          if (bus.op_valid) begin
            op_done_reg <= 1'b1;
            case (bus.op_code)
              3'd0: begin
                op_index_out_reg <= {~(|probe_match), {(31-IW){1'b0}}, probe_idx};
`ifdef TLB_MULTIHIT_EN
                mhit_op_reg      <= multi(probe_match);
`endif
              end
              3'd1: op_rdata_reg <= tbl[bus.op_index];
              3'd2: tbl[bus.op_index] <= bus.op_wdata;
              3'd3: begin
                tbl[random_reg]  <= bus.op_wdata;
                op_index_out_reg <= {{(32-IW){1'b0}}, random_reg};
              end
              3'd4: begin
                state_reg    <= SWEEP;
                op_ready_reg <= 1'b0;
                op_done_reg  <= 1'b0;
                cnt_reg      <= '0;
              end
              default: ;
            endcase
          end
        end
      endcase
    end
  end

  assign bus.rsp_valid    = rsp_valid_reg;
  assign bus.rsp_hit      = rsp_hit_reg;
  assign bus.rsp_paddr    = rsp_paddr_reg;
  assign bus.rsp_v        = rsp_v_reg;
  assign bus.rsp_d        = rsp_d_reg;
  assign bus.rsp_c        = rsp_c_reg;
  assign bus.op_ready     = op_ready_reg;
  assign bus.op_done      = op_done_reg;
  assign bus.op_index_out = op_index_out_reg;
  assign bus.op_rdata     = op_rdata_reg;
  assign bus.random_out   = random_reg;
endmodule

// File: tb/tb_tlb_jtlb_mp.sv
// Directed bench for tlb_jtlb_mp: lookup vector table plus op, Random, FLUSH and reset sequences.
module tb_tlb_jtlb_mp;
  import tlb_jtlb_mp_pkg::*;
  localparam int NE = 16;
  localparam int NP = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  tlb_jtlb_mp_if #(.NUM_ENTRIES(NE), .NUM_PORTS(NP)) bus ();
  tlb_jtlb_mp #(.NUM_ENTRIES(NE), .NUM_PORTS(NP)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    int          port;
    logic [31:0] va;
    logic [7:0]  asid;
    logic        hit;
    logic [31:0] pa;
    logic        v;
    logic        d;
    logic [2:0]  c;
  } vec_t;

  int errors = 0;
  int checks = 0;
  vec_t vecs [8];
  tlb_entry_t e3, e9, e7, e1, ewr, zero_e;
  logic [3:0] exp_r, widx;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic tlb_entry_t mk(input logic [18:0] vpn2, input logic [7:0] a, input logic g,
                                    input logic [19:0] p0, input logic [2:0] c0, input logic d0,
                                    input logic v0, input logic [19:0] p1, input logic [2:0] c1,
                                    input logic d1, input logic v1);
    tlb_entry_t t;
    t.vpn2 = vpn2; t.asid = a; t.g = g;
    t.pfn0 = p0; t.c0 = c0; t.d0 = d0; t.v0 = v0;
    t.pfn1 = p1; t.c1 = c1; t.d1 = d1; t.v1 = v1;
    return t;
  endfunction

  task automatic drive_lookup(input int p, input logic [31:0] va, input logic [7:0] a);
    bus.lk_valid = '0;
    bus.lk_valid[p] = 1'b1;
    bus.lk_vaddr[32*p +: 32] = va;
    bus.asid = a;
  endtask

  task automatic check_port(input string n, input int p, input logic hit, input logic [31:0] pa,
                            input logic v, input logic d, input logic [2:0] c);
    chk({n, ".valid"}, bus.rsp_valid[p], 1'b1);
    chk({n, ".hit"}, bus.rsp_hit[p], hit);
    chk({n, ".paddr"}, bus.rsp_paddr[32*p +: 32], pa);
    chk({n, ".v"}, bus.rsp_v[p], v);
    chk({n, ".d"}, bus.rsp_d[p], d);
    chk({n, ".c"}, bus.rsp_c[3*p +: 3], c);
    $display("lookup %s port%0d hit=%0b paddr=%08h", n, p, bus.rsp_hit[p], bus.rsp_paddr[32*p +: 32]);
  endtask

  task automatic op(input logic [2:0] code, input logic [3:0] idx, input logic [31:0] ehi,
                    input tlb_entry_t wd);
    chk("op_ready", bus.op_ready, 1'b1);
    bus.op_valid = 1'b1; bus.op_code = code; bus.op_index = idx;
    bus.op_entryhi = ehi; bus.op_wdata = wd;
    step();
    bus.op_valid = 1'b0;
    chk("op_done", bus.op_done, 1'b1);
    $display("op code=%0d idx=%0d index_out=%08h", code, idx, bus.op_index_out);
  endtask

  initial begin
    bus.lk_valid = '0; bus.lk_vaddr = '0; bus.asid = '0;
    bus.op_valid = 1'b0; bus.op_code = '0; bus.op_index = '0; bus.op_entryhi = '0;
    bus.op_wdata = '0; bus.wired_we = 1'b0; bus.wired_in = '0;
    zero_e = '0;
    e3  = mk(19'h200, 8'h05, 1'b0, 20'h0ABCD, 3'd2, 1'b0, 1'b1, 20'h12345, 3'd3, 1'b1, 1'b1);
    e9  = mk(19'h800, 8'h77, 1'b1, 20'h00111, 3'd5, 1'b1, 1'b1, 20'h00222, 3'd0, 1'b0, 1'b0);
    e7  = mk(19'h300, 8'h05, 1'b0, 20'h55555, 3'd1, 1'b1, 1'b1, 20'h0, 3'd0, 1'b0, 1'b0);
    e1  = mk(19'h300, 8'h05, 1'b0, 20'h66666, 3'd4, 1'b0, 1'b1, 20'h0, 3'd0, 1'b0, 1'b0);
    ewr = mk(19'hA00, 8'h05, 1'b0, 20'h0F0F0, 3'd7, 1'b1, 1'b1, 20'h0, 3'd0, 1'b0, 1'b0);
    vecs[0] = '{0, 32'h0040_1ABC, 8'h05, 1'b1, 32'h1234_5ABC, 1'b1, 1'b1, 3'd3};
    vecs[1] = '{1, 32'h0040_1ABC, 8'h05, 1'b1, 32'h1234_5ABC, 1'b1, 1'b1, 3'd3};
    vecs[2] = '{0, 32'h0040_0123, 8'h05, 1'b1, 32'h0ABC_D123, 1'b1, 1'b0, 3'd2};
    vecs[3] = '{1, 32'h0040_1ABC, 8'h06, 1'b0, 32'h0, 1'b0, 1'b0, 3'd0};
    vecs[4] = '{0, 32'h0060_1000, 8'h05, 1'b0, 32'h0, 1'b0, 1'b0, 3'd0};
    vecs[5] = '{1, 32'h0100_0FFF, 8'h06, 1'b1, 32'h0011_1FFF, 1'b1, 1'b1, 3'd5};
    vecs[6] = '{0, 32'h0100_1004, 8'h00, 1'b0, 32'h0, 1'b0, 1'b0, 3'd0};
    vecs[7] = '{1, 32'h0100_0000, 8'h77, 1'b1, 32'h0011_1000, 1'b1, 1'b1, 3'd5};

    // Reset state
    step(); step();
    chk("rst.op_ready", bus.op_ready, 1'b1);
    chk("rst.op_done", bus.op_done, 1'b0);
    chk("rst.random", bus.random_out, 4'd15);
    chk("rst.rsp_valid", bus.rsp_valid, 2'b00);
    chk("rst.index_out", bus.op_index_out, 32'h0);
    chk("rst.rdata", bus.op_rdata, zero_e);
    reset = 1'b0;

    // Empty table: all ports miss
    bus.lk_valid = 2'b11; bus.lk_vaddr = {32'h0040_1000, 32'h0040_1000}; bus.asid = 8'h00;
    step();
    bus.lk_valid = '0;
    chk("empty.valid", bus.rsp_valid, 2'b11);
    chk("empty.hit", bus.rsp_hit, 2'b00);
    chk("empty.paddr", bus.rsp_paddr, 64'h0);
    $display("lookup empty hit=%b", bus.rsp_hit);

    op(3'd2, 4'd3, 32'h0, e3);
    op(3'd2, 4'd9, 32'h0, e9);

    for (int i = 0; i < 8; i++) begin
      drive_lookup(vecs[i].port, vecs[i].va, vecs[i].asid);
      step();
      bus.lk_valid = '0;
      chk("vec.other_valid", bus.rsp_valid[1 - vecs[i].port], 1'b0);
      check_port($sformatf("vec%0d", i), vecs[i].port, vecs[i].hit, vecs[i].pa,
                 vecs[i].v, vecs[i].d, vecs[i].c);
    end

    // TLBP hit / miss, TLBR
    op(3'd0, 4'd0, 32'h0040_0005, zero_e);
    chk("tlbp.hit", bus.op_index_out, 32'h0000_0003);
    op(3'd0, 4'd0, 32'h0080_0005, zero_e);
    chk("tlbp.miss", bus.op_index_out, 32'h8000_0000);
    op(3'd1, 4'd3, 32'h0, zero_e);
    chk("tlbr.3", bus.op_rdata, e3);

    // Lookup in the write cycle sees the old table, the next cycle the new entry
    drive_lookup(0, 32'h0060_0010, 8'h05);
    op(3'd2, 4'd7, 32'h0, e7);
    bus.lk_valid = '0;
    chk("samecyc.hit", bus.rsp_hit[0], 1'b0);
    drive_lookup(0, 32'h0060_0010, 8'h05);
    step();
    bus.lk_valid = '0;
    check_port("after_write", 0, 1'b1, 32'h5555_5010, 1'b1, 1'b1, 3'd1);

    // Duplicate at idx 1: lowest index wins
    op(3'd2, 4'd1, 32'h0, e1);
    drive_lookup(0, 32'h0060_0010, 8'h05);
    step();
    bus.lk_valid = '0;
    check_port("dup", 0, 1'b1, 32'h6666_6010, 1'b1, 1'b0, 3'd4);
`ifdef TLB_MULTIHIT_EN
    chk("mhit.lk", bus.mhit[0], 1'b1);
`endif
    op(3'd0, 4'd0, 32'h0060_0005, zero_e);
    chk("tlbp.dup", bus.op_index_out, 32'h0000_0001);
`ifdef TLB_MULTIHIT_EN
    chk("mhit.tlbp", bus.mhit[NP], 1'b1);
    op(3'd0, 4'd0, 32'h0040_0005, zero_e);
    chk("mhit.tlbp_single", bus.mhit[NP], 1'b0);
`endif

    // Random with Wired=4, TLBWR mid-window
    bus.wired_we = 1'b1; bus.wired_in = 4'd4;
    step();
    bus.wired_we = 1'b0;
    exp_r = 4'd15;
    widx = 4'd0;
    for (int k = 0; k < 26; k++) begin
      chk("random", bus.random_out, exp_r);
      if (k == 20) begin
        widx = exp_r;
        op(3'd3, 4'd0, 32'h0, ewr);
        chk("tlbwr.index", bus.op_index_out, {28'h0, widx});
      end else begin
        step();
      end
      exp_r = (exp_r == 4'd4) ? 4'd15 : exp_r - 4'd1;
    end
    $display("random window wired=4 tlbwr_idx=%0d", widx);
    op(3'd1, widx, 32'h0, zero_e);
    chk("tlbwr.rdata", bus.op_rdata, ewr);
    drive_lookup(1, 32'h0140_0020, 8'h05);
    step();
    bus.lk_valid = '0;
    check_port("tlbwr_lk", 1, 1'b1, 32'h0F0F_0020, 1'b1, 1'b1, 3'd7);

    // Wired = NUM_ENTRIES-1 pins Random
    bus.wired_we = 1'b1; bus.wired_in = 4'd15;
    step();
    bus.wired_we = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("random.pinned", bus.random_out, 4'd15);
      step();
    end

    // FLUSH: ready low 16 cycles, done 17 cycles after accept, lookups mid-sweep miss
    chk("flush.ready0", bus.op_ready, 1'b1);
    bus.op_valid = 1'b1; bus.op_code = 3'd4;
    step();
    bus.op_valid = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      chk("flush.ready", bus.op_ready, 1'b0);
      chk("flush.done_early", bus.op_done, 1'b0);
      if (i == 2) drive_lookup(0, 32'h0040_1ABC, 8'h05);
      if (i == 3) begin
        bus.lk_valid = '0;
        chk("sweep.valid", bus.rsp_valid[0], 1'b1);
        chk("sweep.hit", bus.rsp_hit[0], 1'b0);
      end
      step();
    end
    chk("flush.done", bus.op_done, 1'b1);
    chk("flush.ready_back", bus.op_ready, 1'b1);
    $display("flush done op_done=%0b", bus.op_done);
    step();
    chk("flush.done_pulse", bus.op_done, 1'b0);
    bus.lk_valid = 2'b11; bus.lk_vaddr = {32'h0140_0020, 32'h0040_1ABC}; bus.asid = 8'h05;
    step();
    bus.lk_valid = '0;
    chk("postflush.hit", bus.rsp_hit, 2'b00);
    op(3'd1, 4'd3, 32'h0, zero_e);
    chk("postflush.tlbr", bus.op_rdata,
        mk(19'h200, 8'h05, 1'b0, 20'h0ABCD, 3'd2, 1'b0, 1'b0, 20'h12345, 3'd3, 1'b1, 1'b0));

    // Reset during SWEEP aborts without op_done
    bus.op_valid = 1'b1; bus.op_code = 3'd4;
    step();
    bus.op_valid = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk("abort.ready_low", bus.op_ready, 1'b0);
    reset = 1'b1;
    step();
    chk("abort.ready", bus.op_ready, 1'b1);
    chk("abort.random", bus.random_out, 4'd15);
    reset = 1'b0;
    exp_r = 4'd15;
    for (int i = 0; i < 20; i++) begin
      step();
      exp_r = exp_r - 4'd1;
      chk("abort.done", bus.op_done, 1'b0);
      chk("abort.random_run", bus.random_out, exp_r);
    end
    op(3'd1, 4'd3, 32'h0, zero_e);
    chk("abort.tlbr", bus.op_rdata, zero_e);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
